// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  localparam int RAM_AW_DEF = 4;

  // Address bit that routes an access to the I/O region instead of RAM.
  localparam logic [4:0] IO_BASE = 5'h10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef enum logic {
    PORT_M0 = 1'b0,
    PORT_M1 = 1'b1
  } port_t;

endpackage

// File: rtl/dmem_rr_arb2.sv
// Two-way round-robin arbiter. On a tie the port that did not win last time
// is chosen; a lone requester always wins. The pointer starts at m1 so m0
// takes the first tie after reset.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic       valid_o,
  output port_t      winner_o
);

  port_t r_last_gnt;

  // Pick a winner from the current requests and the last-grant pointer.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    valid_o  = |req_i;
    winner_o = PORT_M0;
    if (req_i == 2'b11)
      winner_o = (r_last_gnt == PORT_M1) ? PORT_M0 : PORT_M1;
    else if (req_i[1])
      winner_o = PORT_M1;
  end

  // Remember the most recent winner for the next tie.
  always_ff @(posedge clk_i) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_i)
      r_last_gnt <= PORT_M1;
    else if (valid_o)
      r_last_gnt <= winner_o;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter. Each accepted request becomes a single
// ACCESS cycle that drives either the RAM or the I/O region; read data is
// captured at the end of that cycle and returned with a one-cycle rvalid.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RAM_AW = RAM_AW_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [RAM_AW-1:0] ram_address_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_we_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic [3:0]        io_addr_o,
  output logic [DATA_W-1:0] io_wdata_o,
  output logic              io_we_o,
  output logic              io_re_o,
  input  logic [DATA_W-1:0] io_rdata_i
);

  state_t              r_state;
  state_t              w_state_nxt;
  port_t               r_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_m0_rvalid;
  logic                r_m1_rvalid;
  logic [DATA_W-1:0]   r_m0_rdata;
  logic [DATA_W-1:0]   r_m1_rdata;

  logic                w_access;
  logic                w_active;
  logic                w_is_io;
  logic [1:0]          w_req_eff;
  logic                w_arb_valid;
  port_t               w_winner;
  logic [DATA_W-1:0]   w_rd_data;

  assign w_access = (r_state == ST_ACCESS);
  // Strobes are cut while reset is asserted so an interrupted write never
  // lands at the reset edge.
  assign w_active = w_access & rst_i;
  assign w_is_io  = |(r_addr & ADDR_W'(IO_BASE));
  assign w_rd_data = w_is_io ? io_rdata_i : ram_data_i;

  // The owner's request is still visible during its own grant cycle; it was
  // already consumed, so it must not compete again.
  assign w_req_eff[0] = m0_req_i & ~(w_access & (r_owner == PORT_M0));
  assign w_req_eff[1] = m1_req_i & ~(w_access & (r_owner == PORT_M1));

  rr_arb2 u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (w_req_eff),
    .valid_o  (w_arb_valid),
    .winner_o (w_winner)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next state: any accepted request starts (or continues) an ACCESS cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_arb_valid) w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = w_arb_valid ? ST_ACCESS : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winning operation and return read data one cycle after ACCESS.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_owner     <= PORT_M0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      if (w_arb_valid) begin
        r_owner <= w_winner;
        r_we    <= (w_winner == PORT_M1) ? m1_we_i    : m0_we_i;
        r_addr  <= (w_winner == PORT_M1) ? m1_addr_i  : m0_addr_i;
        r_wdata <= (w_winner == PORT_M1) ? m1_wdata_i : m0_wdata_i;
      end
      r_m0_rvalid <= w_access & ~r_we & (r_owner == PORT_M0);
      r_m1_rvalid <= w_access & ~r_we & (r_owner == PORT_M1);
      if (w_access && !r_we && r_owner == PORT_M0) r_m0_rdata <= w_rd_data;
      if (w_access && !r_we && r_owner == PORT_M1) r_m1_rdata <= w_rd_data;
    end
  end

  // Route the latched operation to exactly one region; the other stays at 0.
  always_comb begin
    ram_address_o = '0;
    ram_data_o    = '0;
    ram_we_o      = 1'b0;
    io_addr_o     = '0;
    io_wdata_o    = '0;
    io_we_o       = 1'b0;
    io_re_o       = 1'b0;
    if (w_active) begin
      if (w_is_io) begin
        io_addr_o  = r_addr[3:0];
        io_wdata_o = r_wdata;
        io_we_o    = r_we;
        io_re_o    = ~r_we;
      end else begin
        ram_address_o = r_addr[RAM_AW-1:0];
        ram_data_o    = r_wdata;
        ram_we_o      = r_we;
      end
    end
  end

  assign m0_gnt_o    = w_access & (r_owner == PORT_M0);
  assign m1_gnt_o    = w_access & (r_owner == PORT_M1);
  assign m0_rvalid_o = r_m0_rvalid;
  assign m1_rvalid_o = r_m1_rvalid;
  assign m0_rdata_o  = r_m0_rdata;
  assign m1_rdata_o  = r_m1_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural RAM and a fixed
// I/O read value.
module tb_dmem_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [4:0] m0_addr_i, m1_addr_i;
  logic [7:0] m0_wdata_i, m1_wdata_i;
  logic       m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
  logic [7:0] m0_rdata_o, m1_rdata_o;
  logic [3:0] ram_address_o;
  logic [7:0] ram_data_o, ram_data_i;
  logic       ram_we_o;
  logic [3:0] io_addr_o;
  logic [7:0] io_wdata_o, io_rdata_i;
  logic       io_we_o, io_re_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [16];

  always #5 clk_i = ~clk_i;

  dmem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .ram_address_o(ram_address_o), .ram_data_o(ram_data_o), .ram_we_o(ram_we_o),
    .ram_data_i(ram_data_i),
    .io_addr_o(io_addr_o), .io_wdata_o(io_wdata_o), .io_we_o(io_we_o), .io_re_o(io_re_o),
    .io_rdata_i(io_rdata_i)
  );

  // Behavioural RAM: asynchronous read, write at the rising edge.
  assign ram_data_i = mem[ram_address_o];
  always @(posedge clk_i) if (ram_we_o) mem[ram_address_o] <= ram_data_o;

  assign io_rdata_i = 8'h5C;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // The strobes must never overlap.
  task automatic check_onehot(input string tag);
    check(tag, 32'(ram_we_o) + 32'(io_we_o) + 32'(io_re_o) <= 1 ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst_i = 1'b0;
    m0_req_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_wdata_i = '0;
    m1_req_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_wdata_i = '0;
    step(); step();

    // Reset state
    check("rst_m0_gnt", m0_gnt_o, 0);
    check("rst_m1_gnt", m1_gnt_o, 0);
    check("rst_m0_rvalid", m0_rvalid_o, 0);
    check("rst_m1_rvalid", m1_rvalid_o, 0);
    check("rst_m0_rdata", m0_rdata_o, 0);
    check("rst_ram_we", ram_we_o, 0);
    check("rst_io_strobes", {io_we_o, io_re_o}, 0);
    check("rst_addrs", {ram_address_o, io_addr_o}, 0);
    rst_i = 1'b1;
    step();

    // m0 write 0x03 <- 0xA5, then read it back
    m0_req_i = 1; m0_we_i = 1; m0_addr_i = 5'h03; m0_wdata_i = 8'hA5;
    step();
    check("wr_m0_gnt", m0_gnt_o, 1);
    check("wr_m1_gnt", m1_gnt_o, 0);
    check("wr_ram_we", ram_we_o, 1);
    check("wr_ram_addr", ram_address_o, 3);
    check("wr_ram_data", ram_data_o, 8'hA5);
    check("wr_io_quiet", {io_we_o, io_re_o, io_addr_o}, 0);
    m0_we_i = 0;
    step();
    check("wr_one_cycle", ram_we_o, 0);
    check("wr_no_rvalid", m0_rvalid_o, 0);
    step();
    check("rd_m0_gnt", m0_gnt_o, 1);
    check("rd_ram_addr", ram_address_o, 3);
    check("rd_ram_we", ram_we_o, 0);
    m0_req_i = 0;
    step();
    check("rd_m0_rvalid", m0_rvalid_o, 1);
    check("rd_m0_rdata", m0_rdata_o, 8'hA5);
    check("rd_m1_rvalid", m1_rvalid_o, 0);
    step();
    check("rd_rvalid_pulse", m0_rvalid_o, 0);
    check("rd_rdata_held", m0_rdata_o, 8'hA5);

    // m1 I/O read 0x12
    m1_req_i = 1; m1_we_i = 0; m1_addr_i = 5'h12;
    step();
    check("ior_m1_gnt", m1_gnt_o, 1);
    check("ior_io_re", io_re_o, 1);
    check("ior_io_we", io_we_o, 0);
    check("ior_io_addr", io_addr_o, 2);
    check("ior_ram_quiet", {ram_we_o, ram_address_o}, 0);
    check_onehot("ior_onehot");
    m1_req_i = 0;
    step();
    check("ior_m1_rvalid", m1_rvalid_o, 1);
    check("ior_m1_rdata", m1_rdata_o, 8'h5C);
    check("ior_m0_rvalid", m0_rvalid_o, 0);
    check("ior_re_done", io_re_o, 0);

    // m1 I/O write 0x1F <- 0x77
    m1_req_i = 1; m1_we_i = 1; m1_addr_i = 5'h1F; m1_wdata_i = 8'h77;
    step();
    check("iow_io_we", io_we_o, 1);
    check("iow_io_wdata", io_wdata_o, 8'h77);
    check("iow_io_addr", io_addr_o, 4'hF);
    check("iow_io_re", io_re_o, 0);
    check("iow_ram_quiet", {ram_we_o, ram_data_o}, 0);
    m1_req_i = 0;
    step();
    check("iow_one_cycle", io_we_o, 0);
    check("iow_no_rvalid", {m0_rvalid_o, m1_rvalid_o}, 0);

    // Held tie after reset: m0, m1, m0, m1
    rst_i = 0;
    step();
    rst_i = 1;
    m0_req_i = 1; m0_we_i = 1; m0_addr_i = 5'h05; m0_wdata_i = 8'h11;
    m1_req_i = 1; m1_we_i = 1; m1_addr_i = 5'h06; m1_wdata_i = 8'h22;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("rr_m0_gnt_%0d", k), m0_gnt_o, (k % 2 == 0) ? 1 : 0);
      check($sformatf("rr_m1_gnt_%0d", k), m1_gnt_o, (k % 2 == 1) ? 1 : 0);
      check($sformatf("rr_ram_addr_%0d", k), ram_address_o, (k % 2 == 0) ? 5 : 6);
    end
    m0_req_i = 0; m1_req_i = 0;
    step();
    check("rr_idle", {m0_gnt_o, m1_gnt_o, ram_we_o}, 0);

    // m1 raised and withdrawn while m0 owns the bus
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 5'h05;
    step();
    check("wd_m0_gnt", m0_gnt_o, 1);
    m1_req_i = 1; m1_we_i = 0; m1_addr_i = 5'h12;
    #2;
    m1_req_i = 0;
    m0_req_i = 0;
    step();
    check("wd_m1_gnt", m1_gnt_o, 0);
    check("wd_no_access", {m0_gnt_o, ram_we_o, io_re_o, io_we_o}, 0);
    check("wd_m0_rdata", m0_rdata_o, 8'h11);
    step();
    check("wd_m1_rvalid", m1_rvalid_o, 0);
    check("wd_m1_gnt_late", m1_gnt_o, 0);

    // Reset during a write: strobe dropped, RAM untouched
    m0_req_i = 1; m0_we_i = 1; m0_addr_i = 5'h07; m0_wdata_i = 8'h99;
    step();
    check("rw_ram_we", ram_we_o, 1);
    rst_i = 0; m0_req_i = 0;
    #1;
    check("rw_we_gated", ram_we_o, 0);
    step();
    rst_i = 1;

    // Reset during a read: no rvalid, rdata cleared, tie goes to m0
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 5'h05;
    step();
    check("rr_m0_gnt", m0_gnt_o, 1);
    rst_i = 0; m0_req_i = 0;
    step();
    check("rrst_gnt", {m0_gnt_o, m1_gnt_o}, 0);
    check("rrst_m0_rvalid", m0_rvalid_o, 0);
    check("rrst_m0_rdata", m0_rdata_o, 0);
    check("rrst_strobes", {ram_we_o, io_we_o, io_re_o}, 0);
    rst_i = 1;
    m0_req_i = 1; m0_we_i = 0; m0_addr_i = 5'h07;
    m1_req_i = 1; m1_we_i = 0; m1_addr_i = 5'h12;
    step();
    check("post_tie_m0", m0_gnt_o, 1);
    check("post_tie_m1", m1_gnt_o, 0);
    m0_req_i = 0;
    step();
    check("post_m1_gnt", m1_gnt_o, 1);
    check("post_io_re", io_re_o, 1);
    check("post_m0_rvalid", m0_rvalid_o, 1);
    check("post_aborted_write", m0_rdata_o, 8'h00);
    m1_req_i = 0;
    step();
    check("post_m1_rvalid", m1_rvalid_o, 1);
    check("post_m1_rdata", m1_rdata_o, 8'h5C);
    check_onehot("post_onehot");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
